line_mem_responder: RTL and testbench



---
 rtl/line_mem_responder_if.sv | 22 ++
 rtl/line_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_line_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_responder_if.sv
// rtl/line_mem_responder_if.sv - line protocol bundle between the cache miss engines and line_mem_responder
interface line_mem_responder_if;
  logic        readM1;
  logic [15:0] address1;
  logic [63:0] data1;
  logic        ack1;
  logic        readM2;
  logic        writeM2;
  logic [15:0] address2;
  logic        ack2;
  logic        busy;

  modport master (
    output readM1, address1, readM2, writeM2, address2,
    input  data1, ack1, ack2, busy
  );

  modport slave (
    input  readM1, address1, readM2, writeM2, address2,
    output data1, ack1, ack2, busy
  );
endinterface

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - two-port line-granular memory model with programmable latency
// and fairness-biased arbitration; LINE_MEM_STATS_EN adds num_reads/num_writes counters.
module line_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  line_mem_responder_if.slave  bus,
  inout  wire  [63:0]          data2
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0]          num_reads,
  output logic [15:0]          num_writes
`endif
);

  localparam int LINE_BITS = ADDR_BITS - 2;
  localparam int CW        = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  last2;
  logic                  port2_q;
  logic                  write_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [63:0]           wdata_q;
  logic [63:0]           data1_q;
  logic [63:0]           data2_q;
  logic                  drive2_q;
  logic                  ack1_q;
  logic                  ack2_q;
  logic                  busy_q;

  logic [63:0]           mem [2**LINE_BITS];

  logic                  pend1;
  logic                  pend2;
  logic                  grant;
  logic                  pick2;
  logic                  new_write;
  logic [LINE_BITS-1:0]  new_line;
  logic                  enter_resp;
  logic                  c_port2;
  logic                  c_write;
  logic [LINE_BITS-1:0]  c_line;
  logic [63:0]           c_wdata;
  logic                  unused_addr;

  assign pend1 = bus.readM1;
  assign pend2 = bus.readM2 | bus.writeM2;
  assign grant = (state == IDLE) && (pend1 || pend2);
  // Port 2 wins unless it also took the previous grant while port 1 waits.
  assign pick2     = pend2 && !(pend1 && last2);
  assign new_write = pick2 && bus.writeM2;
  assign new_line  = pick2 ? bus.address2[ADDR_BITS-1:2] : bus.address1[ADDR_BITS-1:2];

  assign enter_resp = (grant && (LATENCY == 1)) || ((state == BUSY) && (cnt == CW'(1)));

  // With LATENCY=1 the commit happens on the grant edge, before anything is latched.
  assign c_port2 = (state == IDLE) ? pick2     : port2_q;
  assign c_write = (state == IDLE) ? new_write : write_q;
  assign c_line  = (state == IDLE) ? new_line  : line_q;
  assign c_wdata = (state == IDLE) ? data2     : wdata_q;

  assign unused_addr = ^{bus.address1, bus.address2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last2    <= 1'b0;
      port2_q  <= 1'b0;
      write_q  <= 1'b0;
      line_q   <= '0;
      wdata_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      drive2_q <= 1'b0;
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      drive2_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            port2_q <= pick2;
            write_q <= new_write;
            line_q  <= new_line;
            wdata_q <= data2;
            last2   <= pick2;
            busy_q  <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt    <= cnt - CW'(1);
          busy_q <= 1'b1;
          if (cnt == CW'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        ack1_q <= !c_port2;
        ack2_q <= c_port2;
        if (!c_write) begin
          if (c_port2) begin
            data2_q  <= mem[c_line];
            drive2_q <= 1'b1;
          end else begin
            data1_q <= mem[c_line];
          end
        end
      end
    end
  end

  // Storage survives reset; a write is only committed when its transaction reaches RESP.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && c_write) begin
      mem[c_line] <= c_wdata;
    end
  end

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_reads  <= '0;
      num_writes <= '0;
    end else if (enter_resp) begin
      if (c_write) begin
        num_writes <= num_writes + 16'd1;
      end else begin
        num_reads <= num_reads + 16'd1;
      end
    end
  end
`else
  // no transaction counters in this build
`endif

  assign data2     = drive2_q ? data2_q : 'z;
  assign bus.data1 = data1_q;
  assign bus.ack1  = ack1_q;
  assign bus.ack2  = ack2_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - self-checking bench for line_mem_responder (LATENCY=4/ADDR_BITS=16
// and LATENCY=1/ADDR_BITS=8 instances) against a queue/array reference model.
module tb_line_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_mem_responder_if bus_a();
  line_mem_responder_if bus_b();

  wire  [63:0] data2_a;
  wire  [63:0] data2_b;
  logic        drv_a;
  logic        drv_b;
  logic [63:0] wd_a;
  logic [63:0] wd_b;

  assign data2_a = drv_a ? wd_a : 'z;
  assign data2_b = drv_b ? wd_b : 'z;

`ifdef LINE_MEM_STATS_EN
  logic [15:0] nr_a, nw_a, nr_b, nw_b;
`endif

  line_mem_responder #(.LATENCY(LAT), .ADDR_BITS(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .data2 (data2_a)
`ifdef LINE_MEM_STATS_EN
    ,
    .num_reads  (nr_a),
    .num_writes (nw_a)
`endif
  );

  line_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .data2 (data2_b)
`ifdef LINE_MEM_STATS_EN
    ,
    .num_reads  (nr_b),
    .num_writes (nw_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] mref [int];
  bit          last2_m;
  logic [63:0] d1_m;
  bit          have_d1;

  typedef struct {
    bit          r1;
    bit          rd2;
    bit          wr2;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [63:0] wd;
    int          first;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t tab [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_p1(input logic [15:0] a, output logic [63:0] e);
    last2_m = 1'b0;
    e       = mref[int'(a[15:2])];
    d1_m    = e;
    have_d1 = 1'b1;
  endtask

  task automatic model_p2(input bit wr, input logic [15:0] a, input logic [63:0] wd,
                          output logic [63:0] e);
    last2_m = 1'b1;
    e       = '0;
    if (wr) mref[int'(a[15:2])] = wd;
    else    e = mref[int'(a[15:2])];
  endtask

  // One transaction or a simultaneous pair on the LATENCY=4 instance; starts and ends at a negedge.
  task automatic run_round(input bit r1, input bit rd2, input bit wr2,
                           input logic [15:0] a1, input logic [15:0] a2, input logic [63:0] wd,
                           output logic [63:0] got1, output logic [63:0] got2,
                           output int obs_first);
    bit          p2, two, drop1, drop2;
    int          first, t1, t2, end_n, busy_end;
    logic [63:0] e1, e2;
    p2    = rd2 | wr2;
    two   = r1 && p2;
    first = (r1 && (!p2 || last2_m)) ? 1 : 2;
    e1    = '0;
    e2    = '0;
    if (first == 2) begin
      model_p2(wr2, a2, wd, e2);
      if (two) model_p1(a1, e1);
    end else begin
      model_p1(a1, e1);
      if (two) model_p2(wr2, a2, wd, e2);
    end
    t1       = r1 ? ((first == 1) ? LAT : 2 * LAT + 1) : -1;
    t2       = p2 ? ((first == 2) ? LAT : 2 * LAT + 1) : -1;
    end_n    = two ? 2 * LAT + 3 : LAT + 2;
    busy_end = two ? 2 * LAT + 1 : LAT;

    bus_a.readM1   = r1;
    bus_a.address1 = a1;
    bus_a.readM2   = rd2;
    bus_a.writeM2  = wr2;
    bus_a.address2 = a2;
    wd_a           = wd;
    drv_a          = wr2;

    got1 = '0; got2 = '0; obs_first = 0; drop1 = 0; drop2 = 0;
    for (int n = 1; n <= end_n; n++) begin
      @(negedge clk);
      if (drop1) begin bus_a.readM1 = 1'b0; drop1 = 0; end
      if (drop2) begin bus_a.readM2 = 1'b0; bus_a.writeM2 = 1'b0; drv_a = 1'b0; drop2 = 0; end
      chk("ack1", 64'(bus_a.ack1), 64'(n == t1));
      chk("ack2", 64'(bus_a.ack2), 64'(n == t2));
      chk("busy", 64'(bus_a.busy), 64'((n <= busy_end) && !(two && n == LAT + 1)));
      if (obs_first == 0) begin
        if (bus_a.ack1)      obs_first = 1;
        else if (bus_a.ack2) obs_first = 2;
      end
      if (n == t1) begin
        got1 = bus_a.data1;
        chk("data1", got1, e1);
        drop1 = 1;
      end
      if (n == t2) begin
        if (!wr2) begin
          got2 = data2_a;
          chk("data2", got2, e2);
        end
        drop2 = 1;
      end
    end
    if (have_d1) chk("data1_hold", bus_a.data1, d1_m);
  endtask

  // Single-port transaction on the LATENCY=1, ADDR_BITS=8 instance.
  task automatic run_b(input bit r1, input bit rd2, input bit wr2, input logic [15:0] a,
                       input logic [63:0] wd, input logic [63:0] exp);
    bus_b.readM1   = r1;
    bus_b.address1 = a;
    bus_b.readM2   = rd2;
    bus_b.writeM2  = wr2;
    bus_b.address2 = a;
    wd_b           = wd;
    drv_b          = wr2;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 2) begin
        bus_b.readM1 = 1'b0; bus_b.readM2 = 1'b0; bus_b.writeM2 = 1'b0; drv_b = 1'b0;
      end
      chk("b_ack1", 64'(bus_b.ack1), 64'(r1 && n == 1));
      chk("b_ack2", 64'(bus_b.ack2), 64'(!r1 && n == 1));
      chk("b_busy", 64'(bus_b.busy), 64'(n == 1));
      if (n == 1 && r1)  chk("b_data1", bus_b.data1, exp);
      if (n == 1 && rd2) chk("b_data2", data2_b, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] g1, g2, dd, ee;
    int          of, t_ack1, t_ack2a, t_ack2b;
    bit          r1;
    int          op2;

    tab[0] = '{0, 0, 1, 16'h0000, 16'h0012, 64'h1111_2222_3333_4444, 2, 64'h0, 64'h0};
    tab[1] = '{0, 1, 0, 16'h0000, 16'h0010, 64'h0, 2, 64'h0, 64'h1111_2222_3333_4444};
    tab[2] = '{1, 0, 0, 16'h0013, 16'h0000, 64'h0, 1, 64'h1111_2222_3333_4444, 64'h0};
    tab[3] = '{1, 1, 0, 16'h0011, 16'h0012, 64'h0, 2, 64'h1111_2222_3333_4444,
               64'h1111_2222_3333_4444};
    tab[4] = '{1, 0, 1, 16'h0021, 16'h0022, 64'hAAAA_BBBB_CCCC_DDDD, 2,
               64'hAAAA_BBBB_CCCC_DDDD, 64'h0};
    tab[5] = '{0, 1, 1, 16'h0000, 16'h0033, 64'h5555_6666_7777_8888, 2, 64'h0, 64'h0};
    tab[6] = '{0, 1, 0, 16'h0000, 16'h0030, 64'h0, 2, 64'h0, 64'h5555_6666_7777_8888};

    reset = 1'b1;
    bus_a.readM1 = 0; bus_a.address1 = 0; bus_a.readM2 = 0; bus_a.writeM2 = 0; bus_a.address2 = 0;
    bus_b.readM1 = 0; bus_b.address1 = 0; bus_b.readM2 = 0; bus_b.writeM2 = 0; bus_b.address2 = 0;
    drv_a = 0; drv_b = 0; wd_a = 0; wd_b = 0;
    last2_m = 0; d1_m = 0; have_d1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack1", 64'(bus_a.ack1), 64'(0));
    chk("rst_ack2", 64'(bus_a.ack2), 64'(0));
    chk("rst_busy", 64'(bus_a.busy), 64'(0));
    chk("rst_data1", bus_a.data1, 64'h0);
    chk("rst_b_busy", 64'(bus_b.busy), 64'(0));
    chk("rst_b_data1", bus_b.data1, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_round(tab[i].r1, tab[i].rd2, tab[i].wr2, tab[i].a1, tab[i].a2, tab[i].wd, g1, g2, of);
      chk($sformatf("tab%0d_first", i), 64'(of), 64'(tab[i].first));
      if (tab[i].r1)                chk($sformatf("tab%0d_d1", i), g1, tab[i].e1);
      if (tab[i].rd2 && !tab[i].wr2) chk($sformatf("tab%0d_d2", i), g2, tab[i].e2);
    end

    for (int l = 0; l < 16; l++) begin
      run_round(0, 0, 1, 16'h0, 16'((l << 2) | $urandom_range(0, 3)), {$urandom, $urandom},
                g1, g2, of);
    end

    for (int i = 0; i < 60; i++) begin
      r1  = 1'($urandom_range(0, 1));
      op2 = $urandom_range(0, 3);
      if (!r1 && op2 == 0) r1 = 1;
      run_round(r1, op2[0], op2[1], 16'($urandom_range(0, 63)), 16'($urandom_range(0, 63)),
                {$urandom, $urandom}, g1, g2, of);
    end

    // Fairness: readM2 held throughout while readM1 waits; expect grants 2, 1, 2.
    run_round(1, 0, 0, 16'h0004, 16'h0, 64'h0, g1, g2, of);
    bus_a.readM1 = 1; bus_a.address1 = 16'h0008;
    bus_a.readM2 = 1; bus_a.address2 = 16'h000C;
    t_ack1 = -1; t_ack2a = -1; t_ack2b = -1;
    for (int n = 1; n <= 3 * LAT + 5; n++) begin
      @(negedge clk);
      if (t_ack1 > 0 && n == t_ack1 + 1) bus_a.readM1 = 0;
      if (t_ack2b > 0 && n == t_ack2b + 1) bus_a.readM2 = 0;
      if (bus_a.ack1 && t_ack1 < 0) begin
        t_ack1 = n;
        chk("fair_data1", bus_a.data1, mref[2]);
      end
      if (bus_a.ack2) begin
        if (t_ack2a < 0) t_ack2a = n;
        else if (t_ack2b < 0) t_ack2b = n;
        chk("fair_data2", data2_a, mref[3]);
      end
    end
    chk("fair_ack2_first", 64'(t_ack2a), 64'(LAT));
    chk("fair_ack1", 64'(t_ack1), 64'(2 * LAT + 1));
    chk("fair_ack1_bound", 64'(t_ack1 > 0 && t_ack1 <= 2 * (LAT + 1)), 64'(1));
    chk("fair_ack2_second", 64'(t_ack2b), 64'(3 * LAT + 2));
    last2_m = 1; d1_m = mref[2];

    // Early withdrawal: request dropped after the grant still completes and commits.
    dd = 64'hDEAD_BEEF_0123_4567;
    bus_a.writeM2 = 1; bus_a.address2 = 16'h0050; wd_a = dd; drv_a = 1;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clk);
      if (n == 2) begin bus_a.writeM2 = 0; drv_a = 0; end
      chk("wd_ack2", 64'(bus_a.ack2), 64'(n == LAT));
      chk("wd_ack1", 64'(bus_a.ack1), 64'(0));
    end
    mref[16'h0050 >> 2] = dd; last2_m = 1;
    run_round(0, 1, 0, 16'h0, 16'h0050, 64'h0, g1, g2, of);
    chk("wd_readback", g2, dd);

    // Reset two cycles into a write: no ack, busy drops at once, old line kept.
    ee = 64'h0BAD_F00D_CAFE_0001;
    run_round(0, 0, 1, 16'h0, 16'h0040, ee, g1, g2, of);
    bus_a.writeM2 = 1; bus_a.address2 = 16'h0040; wd_a = 64'hFFFF_0000_FFFF_0000; drv_a = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rb_busy_pre", 64'(bus_a.busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("rb_busy", 64'(bus_a.busy), 64'(0));
    chk("rb_ack2", 64'(bus_a.ack2), 64'(0));
    chk("rb_data1", bus_a.data1, 64'h0);
    @(negedge clk);
    bus_a.writeM2 = 0; drv_a = 0;
    @(negedge clk);
    reset = 1'b0;
    last2_m = 0; d1_m = 0;
    for (int n = 0; n < LAT + 2; n++) begin
      @(negedge clk);
      chk("rb_idle_ack2", 64'(bus_a.ack2), 64'(0));
      chk("rb_idle_busy", 64'(bus_a.busy), 64'(0));
    end
    run_round(0, 1, 0, 16'h0, 16'h0040, 64'h0, g1, g2, of);
    chk("rb_old_line", g2, ee);

    // LATENCY=1 instance with 8 address bits: 0x0104 and 0x0004 alias.
    run_b(0, 0, 1, 16'h0104, 64'h0123_4567_89AB_CDEF, 64'h0);
    run_b(0, 1, 0, 16'h0004, 64'h0, 64'h0123_4567_89AB_CDEF);
    run_b(1, 0, 0, 16'h0004, 64'h0, 64'h0123_4567_89AB_CDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
